// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer and the microcode assembler:
// sequencing-op encodings and the micro-address width.
package microseq_pkg;

  localparam int UADDR_W  = 9;
  localparam int SEQ_OP_W = 3;

  localparam logic [SEQ_OP_W-1:0] SEQ_NEXT  = 3'd0;
  localparam logic [SEQ_OP_W-1:0] SEQ_JUMP  = 3'd1;
  localparam logic [SEQ_OP_W-1:0] SEQ_BRT   = 3'd2;
  localparam logic [SEQ_OP_W-1:0] SEQ_BRF   = 3'd3;
  localparam logic [SEQ_OP_W-1:0] SEQ_CALL  = 3'd4;
  localparam logic [SEQ_OP_W-1:0] SEQ_RET   = 3'd5;
  localparam logic [SEQ_OP_W-1:0] SEQ_FETCH = 3'd6;
  localparam logic [SEQ_OP_W-1:0] SEQ_HOLD  = 3'd7;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for micro-subroutines; top entry lives at index sp-1.
// Pushes when full and pops when empty are ignored.
module microseq_stack #(
  parameter  int DEPTH = 4,
  parameter  int W     = 9,
  localparam int SPW   = $clog2(DEPTH) + 1,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [SPW-1:0]  r_sp;
  logic [IDXW-1:0] w_top_idx;

  assign full      = (r_sp == SPW'(DEPTH));
  assign empty     = (r_sp == '0);
  assign sp        = r_sp;
  assign w_top_idx = IDXW'(r_sp - SPW'(1));
  assign top       = empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push && !full) begin
      r_mem[r_sp[IDXW-1:0]] <= din;
      r_sp                  <= r_sp + SPW'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

endmodule

// File: rtl/microseq.sv
// Microprogram sequencer: next-address mux, micro-PC and return stack in front of the microcode ROM.
// Optional sticky overflow/underflow flags on port err are enabled by defining MICROSEQ_ERR_EN.
module microseq
  import microseq_pkg::*;
#(
  parameter int                 STACK_DEPTH = 4,
  parameter logic [UADDR_W-1:0] RESET_ADDR  = 9'h100,
  parameter logic [UADDR_W-1:0] IRQ_ADDR    = 9'h101
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [SEQ_OP_W-1:0]        seq_op,
  input  logic [UADDR_W-1:0]         target,
  input  logic                       cond,
  input  logic [7:0]                 opcode,
  input  logic                       irq,
  output logic [UADDR_W-1:0]         addr,
  output logic [UADDR_W-1:0]         upc,
  output logic [$clog2(STACK_DEPTH):0] sp
`ifdef MICROSEQ_ERR_EN
  ,
  output logic [1:0]                 err
`endif
);

  logic [UADDR_W-1:0] r_upc;
  logic [UADDR_W-1:0] w_upc_inc;
  logic [UADDR_W-1:0] w_next;
  logic [UADDR_W-1:0] w_top;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_upc_inc = r_upc + UADDR_W'(1);
  assign w_push    = enable && (seq_op == SEQ_CALL) && !w_full;
  assign w_pop     = enable && (seq_op == SEQ_RET) && !w_empty;

  always_comb begin
    w_next = r_upc;
    case (seq_op)
      SEQ_NEXT:  w_next = w_upc_inc;
      SEQ_JUMP:  w_next = target;
      SEQ_BRT:   w_next = cond ? target : w_upc_inc;
      SEQ_BRF:   w_next = cond ? w_upc_inc : target;
      SEQ_CALL:  w_next = target;
      SEQ_RET:   w_next = w_empty ? RESET_ADDR : w_top;
      SEQ_FETCH: w_next = irq ? IRQ_ADDR : {1'b0, opcode};
      SEQ_HOLD:  w_next = r_upc;
      default:   w_next = r_upc;
    endcase
  end

  // The ROM sees RESET_ADDR for the whole reset window so its first word after release matches upc.
  assign addr = reset ? w_next : RESET_ADDR;
  assign upc  = r_upc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_upc <= RESET_ADDR;
    else if (enable) r_upc <= w_next;
  end

  microseq_stack #(
    .DEPTH(STACK_DEPTH),
    .W    (UADDR_W)
  ) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .pop  (w_pop),
    .din  (w_upc_inc),
    .top  (w_top),
    .sp   (sp),
    .full (w_full),
    .empty(w_empty)
  );

`ifdef MICROSEQ_ERR_EN
  logic [1:0] r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else if (enable) begin
      if (seq_op == SEQ_CALL && w_full) r_err[0] <= 1'b1;
      if (seq_op == SEQ_RET && w_empty) r_err[1] <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: a reference model pushes expected addr/upc/sp per step,
// observed values are queued alongside and compared inside each scenario task.
module tb_microseq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] seq_op = 3'd0;
  logic [8:0] target = 9'd0;
  logic       cond = 1'b0;
  logic [7:0] opcode = 8'd0;
  logic       irq = 1'b0;
  logic [8:0] addr;
  logic [8:0] upc;
  logic [2:0] sp;
`ifdef MICROSEQ_ERR_EN
  logic [1:0] err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [8:0] addr;
    logic [8:0] upc;
    logic [2:0] sp;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  logic [8:0] m_upc = 9'h100;
  logic [8:0] m_stack[$];

  microseq dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .seq_op(seq_op),
    .target(target),
    .cond  (cond),
    .opcode(opcode),
    .irq   (irq),
    .addr  (addr),
    .upc   (upc),
    .sp    (sp)
`ifdef MICROSEQ_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, model its effect and capture what the DUT shows.
  task automatic drive(input logic [2:0] op, input logic [8:0] tgt, input logic c,
                       input logic [7:0] opc, input logic ir, input logic en);
    rec_t e;
    rec_t o;
    logic [8:0] inc;
    logic [8:0] nxt;
    seq_op = op; target = tgt; cond = c; opcode = opc; irq = ir; enable = en;
    #1;
    inc = m_upc + 9'd1;
    if (!reset) nxt = 9'h100;
    else begin
      case (op)
        3'd0: nxt = inc;
        3'd1: nxt = tgt;
        3'd2: nxt = c ? tgt : inc;
        3'd3: nxt = c ? inc : tgt;
        3'd4: nxt = tgt;
        3'd5: nxt = (m_stack.size() == 0) ? 9'h100 : m_stack[$];
        3'd6: nxt = ir ? 9'h101 : {1'b0, opc};
        default: nxt = m_upc;
      endcase
    end
    e.addr = nxt;
    if (!reset) begin
      m_upc = 9'h100;
      m_stack.delete();
    end else if (en) begin
      if (op == 3'd4 && m_stack.size() < 4) m_stack.push_back(inc);
      if (op == 3'd5 && m_stack.size() > 0) void'(m_stack.pop_back());
      m_upc = nxt;
    end
    e.upc = m_upc;
    e.sp  = 3'(m_stack.size());
    exp_q.push_back(e);
    o.addr = addr;
    @(posedge clk);
    #1;
    o.upc = upc;
    o.sp  = sp;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    rec_t e;
    rec_t o;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      drive(3'($urandom_range(0, 7)), 9'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(3'd0, 9'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL reset addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL reset upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL reset sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  task automatic test_wrap_hold();
    rec_t e;
    rec_t o;
    drive(3'd1, 9'h1FF, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd0, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd4, 9'h0C0, 1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(3'd4, 9'h033 + 9'(i), 1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(3'd5, 9'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    drive(3'd7, 9'h055, 1'b1, 8'h12, 1'b1, 1'b1);
    drive(3'd5, 9'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL wrap_hold addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL wrap_hold upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL wrap_hold sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  task automatic test_branches();
    rec_t e;
    rec_t o;
    for (int op = 2; op <= 3; op++) begin
      for (int c = 1; c >= 0; c--) begin
        drive(3'd1, 9'h020, 1'b0, 8'h0, 1'b0, 1'b1);
        drive(3'(op), 9'h0A0, 1'(c), 8'h0, 1'b1, 1'b1);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL branch addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL branch upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL branch sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  task automatic test_dispatch();
    rec_t e;
    rec_t o;
    drive(3'd6, 9'h1EE, 1'b1, 8'hA9, 1'b0, 1'b1);
    drive(3'd4, 9'h070, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(3'd6, 9'h1EE, 1'b0, 8'hA9, 1'b1, 1'b1);
    drive(3'd5, 9'h000, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(3'd6, 9'h000, 1'b0, 8'hFF, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL dispatch addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL dispatch upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL dispatch sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  task automatic test_nested_calls();
    rec_t e;
    rec_t o;
    drive(3'd1, 9'h010, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd4, 9'h150, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd4, 9'h180, 1'b0, 8'h0, 1'b1, 1'b1);
    drive(3'd5, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd5, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL nested addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL nested upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL nested sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    rec_t e;
    rec_t o;
    drive(3'd1, 9'h030, 1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(3'd4, 9'h040 + 9'(i * 16), 1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(3'd5, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
`ifdef MICROSEQ_ERR_EN
    drive(3'd0, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
    n_total++;
    if (err !== 2'b11) $display("[TB] FAIL err_sticky got %b want 11", err); else n_pass++;
`endif
    drive(3'd4, 9'h090, 1'b0, 8'h0, 1'b0, 1'b1);
    drive(3'd4, 9'h0A0, 1'b0, 8'h0, 1'b0, 1'b1);
    reset = 1'b0;
    drive(3'd5, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
`ifdef MICROSEQ_ERR_EN
    n_total++;
    if (err !== 2'b00) $display("[TB] FAIL err_reset got %b want 00", err); else n_pass++;
`endif
    reset = 1'b1;
    drive(3'd5, 9'h000, 1'b0, 8'h0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total += 3;
      if (o.addr !== e.addr) $display("[TB] FAIL boundary addr got %h want %h", o.addr, e.addr); else n_pass++;
      if (o.upc !== e.upc) $display("[TB] FAIL boundary upc got %h want %h", o.upc, e.upc); else n_pass++;
      if (o.sp !== e.sp) $display("[TB] FAIL boundary sp got %0d want %0d", o.sp, e.sp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap_hold();
    test_branches();
    test_dispatch();
    test_nested_calls();
    test_boundaries();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/microseq.md
Name: microseq

Overview:
- Microprogram sequencer directly upstream of the 512x32 microcode ROM.
- Every cycle it computes the 9-bit ROM address from:
  - the sequencing field decoded from the current ROM word,
  - a condition bit,
  - the fetched opcode,
  - a pending interrupt.
- Holds the micro-PC and a small return-address stack for micro-subroutines.
- The ROM registers its output, so `addr` is combinational from the current ROM word and the `upc` register.

Parameters:
- STACK_DEPTH, 4, number of return-address entries (2..8).
- RESET_ADDR, 9'h100, micro-PC value on reset and RET-underflow target.
- IRQ_ADDR, 9'h101, dispatch address taken at FETCH when `irq` is pending.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  advance strobe; same strobe as the ROM enable
- seq_op  input  3  sequencing op from the current ROM word
- target  input  9  branch/call target from the current ROM word
- cond  input  1  selected branch condition (already muxed by the datapath)
- opcode  input  8  instruction byte from the data bus, valid at FETCH
- irq  input  1  interrupt pending and unmasked (level)
- addr  output  9  next ROM address (combinational)
- upc  output  9  registered micro-PC; equals the address of the ROM word currently on the ROM output
- sp  output  $clog2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH

Behaviour:
- seq_op encodings:
  - 0 NEXT: addr = upc+1
  - 1 JUMP: addr = target
  - 2 BRT: addr = cond ? target : upc+1
  - 3 BRF: addr = cond ? upc+1 : target
  - 4 CALL: addr = target; push upc+1
  - 5 RET: addr = top of stack; pop
  - 6 FETCH: addr = irq ? IRQ_ADDR : {1'b0, opcode}
  - 7 HOLD: addr = upc
- upc+1 is 9-bit, wrapping 9'h1FF -> 9'h000.
- On rising clk with enable=1:
  - upc <= addr;
  - stack and sp update per the op.
- enable=0:
  - no state change;
  - addr is still driven combinationally;
  - no push or pop occurs even if seq_op is CALL/RET.
- Reset (reset=0, asynchronous):
  - upc = RESET_ADDR; sp = 0; stack entries cleared to 0.
  - While reset=0, addr is forced to RESET_ADDR regardless of inputs.
- Release is synchronous to the next clk edge (reset synchroniser lives outside).
- Reset mid-subroutine discards all stack contents.
- Stack is LIFO, entries 9 bits, top at index sp-1.
- CALL with sp==STACK_DEPTH (full):
  - jump to target is still taken;
  - push is dropped;
  - existing entries are preserved.
- RET with sp==0 (empty): addr = RESET_ADDR; sp stays 0.
- Only one push or pop per cycle; no op does both.
- irq is sampled only at FETCH; at all other ops it is ignored.
- FETCH with irq=1 does not push a return address; the IRQ microroutine re-fetches via FETCH.
- Latency:
  - `addr` takes effect on the ROM output one enabled clock later;
  - `upc` tracks the ROM output address exactly because both share `enable`.

Optional Feature:
- MICROSEQ_ERR_EN.
- Defined:
  - adds output err[1:0], sticky;
  - bit0 set on CALL-when-full, bit1 set on RET-when-empty;
  - updates only on enabled cycles;
  - cleared only by reset.
- Not defined:
  - port absent, no flag logic;
  - overflow/underflow handling is otherwise identical.

Decomposition:
- Shared package microseq_pkg holds:
  - seq_op encodings as named localparams SEQ_NEXT..SEQ_HOLD;
  - the 9-bit address width constant UADDR_W.
- The microcode assembler uses the same package/include so ROM fields match.
- One sub-module, microseq_stack:
  - parameterised LIFO with push, pop, top, sp, full, empty;
  - asynchronous active-low reset.
- The top level holds the next-address mux and upc.

Test Plan:
- Reset: hold reset=0 with random inputs -> addr=9'h100, upc=9'h100, sp=0; release, NEXT with enable=1 for 3 clocks -> upc 101,102,103.
- Wrap/hold: force upc=9'h1FF via JUMP target=1FF, then NEXT -> upc=9'h000; enable=0 with CALL for 5 cycles -> upc and sp unchanged.
- Branches: upc=9'h020, BRT target=9'h0A0:
  - cond=1 -> upc=9'h0A0; cond=0 -> upc=9'h021;
  - BRF is the mirror image.
- Dispatch: FETCH with opcode=8'hA9, irq=0 -> upc=9'h0A9; FETCH with opcode=8'hA9, irq=1 -> upc=9'h101, sp unchanged.
- Nested calls: from upc=9'h010, CALL 9'h150, then from 9'h150 CALL 9'h180, RET, RET -> upc sequence 150,180,151,011 and sp 1,2,1,0.
- Boundaries: 5 CALLs with depth 4 -> sp=4, 5th target taken; 4 RETs return correct addresses; 5th RET -> upc=9'h100. With MICROSEQ_ERR_EN -> err=2'b11 until reset.
